// File: rtl/uart_pkg.sv
// Shared definitions for the UART DMA memory arbiter: access-width codes,
// arbiter FSM encoding and the requester identifiers used for round-robin.
package uart_pkg;

  typedef enum logic [1:0] {
    MEM_ACC_8  = 2'd0,
    MEM_ACC_16 = 2'd1,
    MEM_ACC_32 = 2'd2
  } mem_acc_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT_TX = 2'd1,
    ST_GRANT_RX = 2'd2,
    ST_DONE     = 2'd3
  } arb_state_e;

  localparam logic SERVED_TX = 1'b0;
  localparam logic SERVED_RX = 1'b1;

  // Wide enough to hold TIMEOUT_CYCLES itself, so the counter never wraps.
  function automatic int cnt_width(input int timeout_cycles);
    if (timeout_cycles < 1) begin
      return 1;
    end else begin
      return $clog2(timeout_cycles + 1);
    end
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Two-way round-robin select between the TX and RX DMA requesters.
module uart_rr_pick
  import uart_pkg::*;
(
  input  logic tx_req,
  input  logic rx_req,
  input  logic last_served,
  output logic grant_valid,
  output logic grant_rx
);

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant_valid = tx_req | rx_req;
    if (tx_req && rx_req) begin
      grant_rx = (last_served == SERVED_TX);
    end else if (rx_req) begin
      grant_rx = 1'b1;
    end else begin
      grant_rx = 1'b0;
    end
  end

endmodule

// File: rtl/uart_mem_arbiter.sv
// Arbitrates TX DMA reads and RX DMA writes onto one shared memory port,
// with a per-grant timeout and a sticky timeout error flag.
module uart_mem_arbiter
  import uart_pkg::*;
#(
  parameter int M_WIDTH        = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tx_req,
  input  logic [M_WIDTH-1:0] tx_addr,
  input  logic [1:0]         tx_width,
  output logic [M_WIDTH-1:0] tx_data_out,
  output logic               tx_ready,
  input  logic               rx_req,
  input  logic [M_WIDTH-1:0] rx_addr,
  input  logic [1:0]         rx_width,
  input  logic [M_WIDTH-1:0] rx_data,
  output logic               rx_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic [M_WIDTH-1:0] mem_addr,
  output logic [1:0]         mem_width,
  output logic [M_WIDTH-1:0] mem_data_out,
  input  logic [M_WIDTH-1:0] mem_data_in,
  input  logic               mem_ready,
  output logic               timeout_err,
  input  logic               err_clr
);

  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  arb_state_e         state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s, cnt_inc_s;
  logic               last_served_r, last_served_s;
  logic               pick_valid_s, pick_rx_s, granted_rx_s, err_set_s;
  logic               mem_req_s, mem_we_s, tx_ready_s, rx_ready_s, timeout_err_s;
  logic [M_WIDTH-1:0] mem_addr_s, mem_data_out_s, tx_data_out_s;
  logic [1:0]         mem_width_s;

  uart_rr_pick u_rr_pick (
    .tx_req      (tx_req),
    .rx_req      (rx_req),
    .last_served (last_served_r),
    .grant_valid (pick_valid_s),
    .grant_rx    (pick_rx_s)
  );

  // Next-state and next-output logic; every registered output is computed here.
  always_comb begin
    state_s        = state_r;
    cnt_s          = cnt_r;
    last_served_s  = last_served_r;
    mem_req_s      = mem_req;
    mem_we_s       = mem_we;
    mem_addr_s     = mem_addr;
    mem_width_s    = mem_width;
    mem_data_out_s = mem_data_out;
    tx_data_out_s  = tx_data_out;
    tx_ready_s     = 1'b0;
    rx_ready_s     = 1'b0;
    err_set_s      = 1'b0;
    cnt_inc_s      = cnt_r + CNT_ONE;
    granted_rx_s   = (state_r == ST_GRANT_RX);

    case (state_r)
      ST_IDLE: begin
        if (pick_valid_s) begin
          mem_req_s = 1'b1;
          cnt_s     = '0;
          if (pick_rx_s) begin
            state_s        = ST_GRANT_RX;
            mem_we_s       = 1'b1;
            mem_addr_s     = rx_addr;
            mem_width_s    = rx_width;
            mem_data_out_s = rx_data;
          end else begin
            state_s        = ST_GRANT_TX;
            mem_we_s       = 1'b0;
            mem_addr_s     = tx_addr;
            mem_width_s    = tx_width;
            mem_data_out_s = '0;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_GRANT_TX, ST_GRANT_RX: begin
        // mem_ready outranks a timeout landing on the same edge.
        if (mem_ready) begin
          state_s       = ST_DONE;
          mem_req_s     = 1'b0;
          tx_ready_s    = !granted_rx_s;
          rx_ready_s    = granted_rx_s;
          last_served_s = granted_rx_s ? SERVED_RX : SERVED_TX;
          if (granted_rx_s) begin
            tx_data_out_s = tx_data_out;
          end else begin
            tx_data_out_s = mem_data_in;
          end
        end else if (cnt_inc_s == CNT_MAX) begin
          state_s       = ST_DONE;
          mem_req_s     = 1'b0;
          cnt_s         = cnt_inc_s;
          err_set_s     = 1'b1;
          tx_ready_s    = !granted_rx_s;
          rx_ready_s    = granted_rx_s;
          last_served_s = granted_rx_s ? SERVED_RX : SERVED_TX;
          if (granted_rx_s) begin
            tx_data_out_s = tx_data_out;
          end else begin
            tx_data_out_s = '0;
          end
        end else begin
          cnt_s = cnt_inc_s;
        end
      end

      ST_DONE: begin
        state_s = ST_IDLE;
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase

    if (err_set_s) begin
      timeout_err_s = 1'b1;
    end else if (err_clr) begin
      timeout_err_s = 1'b0;
    end else begin
      timeout_err_s = timeout_err;
    end
  end

  // State, counter and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      cnt_r         <= '0;
      last_served_r <= SERVED_TX;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_width     <= 2'd0;
      mem_data_out  <= '0;
      tx_data_out   <= '0;
      tx_ready      <= 1'b0;
      rx_ready      <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      last_served_r <= last_served_s;
      mem_req       <= mem_req_s;
      mem_we        <= mem_we_s;
      mem_addr      <= mem_addr_s;
      mem_width     <= mem_width_s;
      mem_data_out  <= mem_data_out_s;
      tx_data_out   <= tx_data_out_s;
      tx_ready      <= tx_ready_s;
      rx_ready      <= rx_ready_s;
      timeout_err   <= timeout_err_s;
    end
  end

endmodule

// File: doc/uart_mem_arbiter.md
UART_MEM_ARBITER -- requirements
Module: uart_mem_arbiter

Interface
REQ-001 Parameter M_WIDTH, default 32: address/data width.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: maximum cycles a grant waits for mem_ready before it is aborted.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  system clock, all logic on rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 tx_req  in  1  TX DMA read request; held with tx_addr/tx_width stable until tx_ready.
REQ-007 tx_addr  in  M_WIDTH  TX read address.
REQ-008 tx_width  in  2  TX access width (MEM_ACC_8/16/32).
REQ-009 tx_data_out  out  M_WIDTH  read data returned to TX, valid while tx_ready=1.
REQ-010 tx_ready  out  1  one-cycle TX completion pulse.
REQ-011 rx_req  in  1  RX DMA write request; held with rx_addr/rx_width/rx_data stable until rx_ready.
REQ-012 rx_addr  in  M_WIDTH  RX write address.
REQ-013 rx_width  in  2  RX access width.
REQ-014 rx_data  in  M_WIDTH  RX write data.
REQ-015 rx_ready  out  1  one-cycle RX completion pulse.
REQ-016 mem_req  out  1  shared memory port request, registered.
REQ-017 mem_we  out  1  1=write (RX grant), 0=read (TX grant).
REQ-018 mem_addr, mem_width, mem_data_out  out  M_WIDTH/2/M_WIDTH  registered copies of the granted requester's fields; mem_data_out=0 on reads.
REQ-019 mem_data_in  in  M_WIDTH  memory read data, valid with mem_ready.
REQ-020 mem_ready  in  1  memory completion pulse.
REQ-021 timeout_err  out  1  sticky flag: a grant was aborted by timeout.
REQ-022 err_clr  in  1  clears timeout_err.

Function
REQ-023 FSM states: IDLE, GRANT_TX, GRANT_RX, DONE.
REQ-024 IDLE: no request -> stay; one request -> grant it; both -> grant the requester not served last (round-robin), with RX winning the first tie after reset.
REQ-025 On entering GRANT_x, mem_req and all mem_* fields are registered from the winner on the same edge; mem_req stays 1 and the fields stay frozen until the grant ends.
REQ-026 GRANT_x with mem_ready=1: mem_req<=0, capture mem_data_in into tx_data_out (TX only), pulse x_ready for exactly one cycle, go to DONE.
REQ-027 DONE lasts one cycle and then goes to IDLE; requests are not sampled in DONE, so a requester that drops req on the x_ready edge is never granted twice.
REQ-028 Minimum latency is 3 cycles from req seen in IDLE to x_ready with zero-wait memory (grant edge, mem_ready edge, ready pulse).
REQ-029 Timeout counter: cleared on grant entry, increments each GRANT cycle without mem_ready; reaching TIMEOUT_CYCLES forces mem_req<=0, pulses x_ready with tx_data_out=0, sets timeout_err, and goes to DONE.
REQ-030 mem_ready arriving in IDLE or DONE is ignored; mem_ready on the same edge as the timeout takes priority (normal completion, no error).
REQ-031 err_clr clears timeout_err; a timeout on the same edge as err_clr leaves timeout_err=1.
REQ-032 last_served updates only on completion or timeout.
REQ-033 The counter is ceil(log2(TIMEOUT_CYCLES+1)) bits wide and never wraps.

Reset
REQ-034 While rst=1: state=IDLE; mem_req, mem_we, tx_ready, rx_ready, timeout_err=0; mem_addr, mem_width, mem_data_out, tx_data_out=0; counter=0; last_served=TX.
REQ-035 Reset mid-grant abandons the transfer with no ready pulse; the requester must reissue.

Structure
REQ-036 MEM_ACC_8/16/32 codes and the FSM state encoding shall live in the shared uart package.
REQ-037 A single sub-module, uart_rr_pick (2-way round-robin priority select), is permitted; everything else stays flat.

Verification
REQ-038 tx_req alone, addr=0x100, width=MEM_ACC_32, memory answers 0xDEADBEEF after 2 waits -> mem_we=0, mem_addr=0x100, tx_ready for 1 cycle with tx_data_out=0xDEADBEEF.
REQ-039 tx_req and rx_req asserted together from reset, each repeating 3 times -> grant order RX,TX,RX,TX,RX,TX; mem_req never overlaps two grants.
REQ-040 rx_req, addr=0x200, data=0x55, width=MEM_ACC_8, mem_ready withheld, TIMEOUT_CYCLES=4 -> mem_req drops after 4 cycles, rx_ready pulses once, timeout_err=1; err_clr -> 0.
REQ-041 Spurious mem_ready in IDLE -> no ready pulse and no state change; mem_ready on the timeout edge -> normal completion, timeout_err stays 0.
REQ-042 rst asserted while GRANT_TX is active -> all outputs 0 immediately (asynchronously), no tx_ready; after release a new tx_req completes normally.
